// File: rtl/soc_ctx_out_port.sv
`default_nettype none
// ============================================================================
// Module      : soc_ctx_out_port
// Description : Avalon-MM write-side output port. Software writes a word that
//               is presented to a consumer with a valid/ack handshake, plus
//               busy/done/overflow/timeout status and a completion interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module soc_ctx_out_port #(
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE    = '0,
    parameter int                    TIMEOUT_CYCLES = 1023,
    parameter int                    CNT_WIDTH      = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  out_valid,
    input  logic                  out_ack,
    output logic                  irq
);

    localparam logic [1:0] c_addr_data   = 2'd0;
    localparam logic [1:0] c_addr_status = 2'd1;
    localparam logic [1:0] c_addr_ctrl   = 2'd2;

    localparam bit                   c_tmo_en   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0] c_tmo_last =
        CNT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;
    logic                  tmo_q, tmo_d;
    logic                  irq_en_q, irq_en_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [31:0]           readdata_q, readdata_d;

    logic w_wr;
    logic w_wr_data;
    logic w_wr_status;
    logic w_accept;
    logic w_ack_evt;
    logic w_tmo_evt;

    assign w_wr        = chipselect & ~write_n;
    assign w_wr_data   = w_wr & (address == c_addr_data);
    assign w_wr_status = w_wr & (address == c_addr_status);
    // Busy is judged on the pre-edge state, so a write racing an ack is rejected.
    assign w_accept    = w_wr_data & ~valid_q;
    assign w_ack_evt   = valid_q & out_ack;
    assign w_tmo_evt   = c_tmo_en & valid_q & ~out_ack & (cnt_q == c_tmo_last);

    always_comb begin
        data_d     = data_q;
        valid_d    = valid_q;
        done_d     = done_q;
        ovf_d      = ovf_q;
        tmo_d      = tmo_q;
        irq_en_d   = irq_en_q;
        cnt_d      = '0;
        readdata_d = 32'd0;

        if (w_accept) begin
            data_d  = writedata[DATA_WIDTH-1:0];
            valid_d = 1'b1;
        end else if (w_ack_evt || w_tmo_evt) begin
            valid_d = 1'b0;
        end

        if (valid_q && !out_ack && !w_tmo_evt) begin
            cnt_d = cnt_q + 1'b1;
        end

        // Clears are applied first so a coincident set event wins.
        if (w_wr_status && writedata[1]) done_d = 1'b0;
        if (w_wr_status && writedata[2]) ovf_d  = 1'b0;
        if (w_wr_status && writedata[3]) tmo_d  = 1'b0;
        if (w_accept)                    done_d = 1'b0;
        if (w_ack_evt)                   done_d = 1'b1;
        if (w_wr_data && valid_q)        ovf_d  = 1'b1;
        if (w_tmo_evt)                   tmo_d  = 1'b1;

        if (w_wr && (address == c_addr_ctrl)) begin
            irq_en_d = writedata[0];
        end

        case (address)
            c_addr_data:   readdata_d = 32'(data_q);
            c_addr_status: readdata_d = {28'd0, tmo_q, ovf_q, done_q, valid_q};
            c_addr_ctrl:   readdata_d = {31'd0, irq_en_q};
            default:       readdata_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= RESET_VALUE;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            tmo_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            cnt_q      <= '0;
            readdata_q <= 32'd0;
        end else begin
            data_q     <= data_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            tmo_q      <= tmo_d;
            irq_en_q   <= irq_en_d;
            cnt_q      <= cnt_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata  = readdata_q;
    assign out_port  = data_q;
    assign out_valid = valid_q;
    assign irq       = done_q & irq_en_q;

endmodule
`default_nettype wire

// File: tb/tb_soc_ctx_out_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_soc_ctx_out_port
// Description : Self-checking bench for soc_ctx_out_port: directed scenarios
//               plus randomized traffic against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_soc_ctx_out_port;

    localparam int TMO = 8;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] out_port;
    logic        out_valid;
    logic        out_ack;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the transfer as seen by software and the consumer.
    logic [31:0] m_data;
    bit          m_busy, m_done, m_ovf, m_tmo, m_irqen;
    int          m_age;
    logic [31:0] m_rd;

    soc_ctx_out_port #(
        .DATA_WIDTH    (32),
        .RESET_VALUE   (32'h0),
        .TIMEOUT_CYCLES(TMO),
        .CNT_WIDTH     (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_data = 32'h0; m_busy = 0; m_done = 0; m_ovf = 0; m_tmo = 0;
        m_irqen = 0; m_age = 0; m_rd = 32'h0;
    endtask

    // One bus cycle: drive, advance the model past the edge, return at edge+1.
    task automatic cyc(input logic [1:0] a, input logic cs, input logic wr,
                       input logic [31:0] wd, input logic ack);
        bit          wr_any, wr_data, wr_stat, accept, completed, timed;
        logic [31:0] n_rd;
        bit          n_done, n_ovf, n_tmo;
        address = a; chipselect = cs; write_n = ~wr; writedata = wd; out_ack = ack;
        wr_any  = cs && wr;
        wr_data = wr_any && (a == 2'd0);
        wr_stat = wr_any && (a == 2'd1);
        case (a)
            2'd0:    n_rd = m_data;
            2'd1:    n_rd = {28'd0, m_tmo, m_ovf, m_done, m_busy};
            2'd2:    n_rd = {31'd0, m_irqen};
            default: n_rd = 32'd0;
        endcase
        accept    = wr_data && !m_busy;
        completed = m_busy && ack;
        timed     = m_busy && !ack && (m_age == TMO - 1);
        n_done = (m_done && !(wr_stat && wd[1]) && !accept) || completed;
        n_ovf  = (m_ovf  && !(wr_stat && wd[2])) || (wr_data && m_busy);
        n_tmo  = (m_tmo  && !(wr_stat && wd[3])) || timed;
        @(posedge clk);
        #1;
        m_rd = n_rd;
        m_done = n_done; m_ovf = n_ovf; m_tmo = n_tmo;
        if (wr_any && a == 2'd2) m_irqen = wd[0];
        if (accept) begin
            m_data = wd; m_busy = 1; m_age = 0;
        end else if (completed || timed) begin
            m_busy = 0; m_age = 0;
        end else if (m_busy) begin
            m_age = m_age + 1;
        end
    endtask

    task automatic idle(input logic ack);
        cyc(2'd0, 1'b0, 1'b0, 32'h0, ack);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            cyc(k[1:0], 1'b1, 1'b0, 32'h0, 1'b0);
            n_checks++;
            if (readdata !== 32'h0) begin
                n_fail++; $display("FAIL reset_read%0d got=%h exp=0", k, readdata);
            end
        end
        n_checks++;
        if (out_valid !== 1'b0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL reset_outs got valid=%b irq=%b exp 0/0", out_valid, irq);
        end
    endtask

    task automatic test_handshake();
        cyc(2'd0, 1'b1, 1'b1, 32'h0000_00A5, 1'b0);
        n_checks++;
        if (out_port !== 32'hA5 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL hs_present got port=%h valid=%b exp a5/1", out_port, out_valid);
        end
        for (int k = 0; k < 3; k++) idle(1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || out_port !== 32'hA5) begin
            n_fail++; $display("FAIL hs_hold got port=%h valid=%b exp a5/1", out_port, out_valid);
        end
        idle(1'b1);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL hs_ack_drop got valid=%b exp 0", out_valid);
        end
        cyc(2'd1, 1'b1, 1'b0, 32'h0, 1'b0);
        n_checks++;
        if (readdata !== 32'h2) begin
            n_fail++; $display("FAIL hs_status got=%h exp=2", readdata);
        end
    endtask

    task automatic test_overflow();
        cyc(2'd0, 1'b1, 1'b1, 32'h11, 1'b0);
        cyc(2'd0, 1'b1, 1'b1, 32'h22, 1'b0);
        n_checks++;
        if (out_port !== 32'h11 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL ovf_drop got port=%h valid=%b exp 11/1", out_port, out_valid);
        end
        cyc(2'd1, 1'b1, 1'b0, 32'h0, 1'b0);
        n_checks++;
        if (readdata !== 32'h5) begin
            n_fail++; $display("FAIL ovf_status got=%h exp=5", readdata);
        end
        cyc(2'd1, 1'b1, 1'b1, 32'h4, 1'b0);
        cyc(2'd1, 1'b1, 1'b0, 32'h0, 1'b0);
        n_checks++;
        if (readdata !== 32'h1) begin
            n_fail++; $display("FAIL ovf_w1c got=%h exp=1", readdata);
        end
        idle(1'b1);
    endtask

    task automatic test_timeout();
        int high = 0;
        cyc(2'd0, 1'b1, 1'b1, 32'h33, 1'b0);
        for (int k = 0; k < 20; k++) begin
            if (out_valid === 1'b1) high++;
            idle(1'b0);
        end
        n_checks++;
        if (high != TMO) begin
            n_fail++; $display("FAIL tmo_len got=%0d cycles exp=%0d", high, TMO);
        end
        cyc(2'd1, 1'b1, 1'b0, 32'h0, 1'b0);
        n_checks++;
        if (readdata !== 32'h8) begin
            n_fail++; $display("FAIL tmo_status got=%h exp=8", readdata);
        end
        cyc(2'd0, 1'b1, 1'b1, 32'h44, 1'b0);
        n_checks++;
        if (out_port !== 32'h44 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL tmo_rewrite got port=%h valid=%b exp 44/1", out_port, out_valid);
        end
        idle(1'b1);
        cyc(2'd1, 1'b1, 1'b1, 32'hE, 1'b0);
    endtask

    task automatic test_simultaneous();
        cyc(2'd0, 1'b1, 1'b1, 32'h66, 1'b0);
        cyc(2'd0, 1'b1, 1'b1, 32'h77, 1'b1);
        n_checks++;
        if (out_valid !== 1'b0 || out_port !== 32'h66) begin
            n_fail++; $display("FAIL sim_wr_ack got port=%h valid=%b exp 66/0", out_port, out_valid);
        end
        cyc(2'd1, 1'b1, 1'b0, 32'h0, 1'b0);
        n_checks++;
        if (readdata !== 32'h6) begin
            n_fail++; $display("FAIL sim_status got=%h exp=6", readdata);
        end
        cyc(2'd1, 1'b1, 1'b1, 32'hE, 1'b0);
    endtask

    task automatic test_sticky_race();
        cyc(2'd0, 1'b1, 1'b1, 32'h88, 1'b0);
        cyc(2'd1, 1'b1, 1'b1, 32'h2, 1'b1);
        cyc(2'd1, 1'b1, 1'b0, 32'h0, 1'b0);
        n_checks++;
        if (readdata !== 32'h2) begin
            n_fail++; $display("FAIL race_done got=%h exp=2", readdata);
        end
        cyc(2'd1, 1'b1, 1'b1, 32'hE, 1'b0);
    endtask

    task automatic test_irq();
        cyc(2'd2, 1'b1, 1'b1, 32'h1, 1'b0);
        cyc(2'd0, 1'b1, 1'b1, 32'h99, 1'b0);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL irq_early got=%b exp=0", irq);
        end
        idle(1'b1);
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++; $display("FAIL irq_set got=%b exp=1", irq);
        end
        cyc(2'd1, 1'b1, 1'b1, 32'h2, 1'b0);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL irq_clear got=%b exp=0", irq);
        end
    endtask

    task automatic test_reset_mid();
        cyc(2'd0, 1'b1, 1'b1, 32'h55, 1'b0);
        idle(1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_port !== 32'h0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL rst_async got port=%h valid=%b irq=%b exp 0/0/0",
                               out_port, out_valid, irq);
        end
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(k[1:0], 1'b1, 1'b0, 32'h0, 1'b0);
            n_checks++;
            if (readdata !== 32'h0) begin
                n_fail++; $display("FAIL rst_read%0d got=%h exp=0", k, readdata);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  a;
        logic [31:0] wd;
        logic        ack;
        for (int n = 0; n < 600; n++) begin
            ack = ($urandom_range(0, 5) == 0);
            wd  = $urandom;
            a   = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0, 1, 2: cyc(2'd0, 1'b1, 1'b1, wd, ack);
                3:       cyc(2'd1, 1'b1, 1'b1, {28'd0, wd[3:0]}, ack);
                4:       cyc(2'd2, 1'b1, 1'b1, wd, ack);
                5:       cyc(a, 1'b0, 1'b1, wd, ack);
                6:       cyc(2'd3, 1'b1, 1'b1, wd, ack);
                default: cyc(a, wd[0], 1'b0, wd, ack);
            endcase
            n_checks++;
            if (out_port !== m_data || out_valid !== m_busy) begin
                n_fail++; $display("FAIL rnd_out got port=%h valid=%b exp %h/%b",
                                   out_port, out_valid, m_data, m_busy);
            end
            n_checks++;
            if (readdata !== m_rd) begin
                n_fail++; $display("FAIL rnd_read got=%h exp=%h", readdata, m_rd);
            end
            n_checks++;
            if (irq !== (m_done && m_irqen)) begin
                n_fail++; $display("FAIL rnd_irq got=%b exp=%b", irq, m_done && m_irqen);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = 32'h0; out_ack = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        test_reset();
        test_handshake();
        test_overflow();
        test_timeout();
        test_simultaneous();
        test_sticky_race();
        test_irq();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
